// File: rtl/cordic_rotacao_seno_cosseno.sv
// Iterative rotation-mode CORDIC producing cos/sin in Q16.16.
// A quadrant code from the upstream correction stage maps the result back to the original angle.
module cordic_rotacao_seno_cosseno #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] z_in,
    input  logic        [2:0]       quadrante,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ROTATE  = 2'd1,
        S_CORRECT = 2'd2
    } state_t;

    // atan(2^-i) scaled by 2^16
    function automatic logic signed [WIDTH-1:0] atan_lut(input logic [CNT_W-1:0] idx);
        case (idx)
            5'd0:    return WIDTH'(51472);
            5'd1:    return WIDTH'(30386);
            5'd2:    return WIDTH'(16055);
            5'd3:    return WIDTH'(8150);
            5'd4:    return WIDTH'(4091);
            5'd5:    return WIDTH'(2047);
            5'd6:    return WIDTH'(1024);
            5'd7:    return WIDTH'(512);
            5'd8:    return WIDTH'(256);
            5'd9:    return WIDTH'(128);
            5'd10:   return WIDTH'(64);
            5'd11:   return WIDTH'(32);
            5'd12:   return WIDTH'(16);
            5'd13:   return WIDTH'(8);
            5'd14:   return WIDTH'(4);
            5'd15:   return WIDTH'(2);
            default: return WIDTH'(0);
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic        [CNT_W-1:0] i_q, i_d;
    logic        [2:0]       q_q, q_d;
    logic signed [WIDTH-1:0] cos_q, cos_d;
    logic signed [WIDTH-1:0] sin_q, sin_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_ROTATE;
            S_ROTATE:  if (i_q == CNT_W'(ITER - 1)) state_d = S_CORRECT;
            S_CORRECT: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic; old x/y feed both cross terms of a micro-rotation
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        i_d    = i_q;
        q_d    = q_q;
        cos_d  = cos_q;
        sin_d  = sin_q;
        done_d = 1'b0;
        busy_d = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    x_d = WIDTH'(39797);
                    y_d = '0;
                    z_d = z_in;
                    q_d = quadrante;
                    i_d = '0;
                end
            end
            S_ROTATE: begin
                if (!z_q[WIDTH-1]) begin
                    x_d = x_q - (y_q >>> i_q);
                    y_d = y_q + (x_q >>> i_q);
                    z_d = z_q - atan_lut(i_q);
                end else begin
                    x_d = x_q + (y_q >>> i_q);
                    y_d = y_q - (x_q >>> i_q);
                    z_d = z_q + atan_lut(i_q);
                end
                i_d = i_q + CNT_W'(1);
            end
            S_CORRECT: begin
                done_d = 1'b1;
                case (q_q)
                    3'd1: begin
                        cos_d = -y_q;
                        sin_d = x_q;
                    end
                    3'd2, 3'd3: begin
                        cos_d = -x_q;
                        sin_d = -y_q;
                    end
                    3'd4: begin
                        cos_d = y_q;
                        sin_d = -x_q;
                    end
                    default: begin
                        cos_d = x_q;
                        sin_d = y_q;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            i_q    <= '0;
            q_q    <= '0;
            cos_q  <= '0;
            sin_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            i_q    <= i_d;
            q_q    <= q_d;
            cos_q  <= cos_d;
            sin_q  <= sin_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign cos_out = cos_q;
    assign sin_out = sin_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_cordic_rotacao_seno_cosseno.sv
// Directed vector bench for the CORDIC sin/cos engine: latency, quadrant mapping,
// ignored restarts, mid-operation reset and back-to-back throughput.
module tb_cordic_rotacao_seno_cosseno;

    localparam int unsigned WIDTH = 32;
    localparam int          TOL   = 16;

    logic                    clk;
    logic                    rst;
    logic                    enable;
    logic signed [WIDTH-1:0] z_in;
    logic        [2:0]       quadrante;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] sin_out;
    logic                    busy;
    logic                    done;

    int total;
    int bad;

    cordic_rotacao_seno_cosseno #(.WIDTH(WIDTH), .ITER(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .z_in     (z_in),
        .quadrante(quadrante),
        .cos_out  (cos_out),
        .sin_out  (sin_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       z;
        logic [2:0] q;
        int       exp_cos;
        int       exp_sin;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int diff;
        total++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Waits up to 40 edges for done; returns edges counted from the sampling edge, or -1
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Issues a one-cycle enable pulse and returns the observed latency
    task automatic start_op(input int z, input logic [2:0] q, input string name, output int lat);
        @(negedge clk);
        enable    = 1'b1;
        z_in      = WIDTH'(z);
        quadrante = q;
        @(posedge clk);
        #1;
        chk({name, " busy_after_start"}, int'(busy), 1, 0);
        @(negedge clk);
        enable = 1'b0;
        wait_done(lat);
        chk({name, " latency"}, lat, 17, 0);
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        int dones;
        total     = 0;
        bad       = 0;
        enable    = 1'b0;
        z_in      = '0;
        quadrante = '0;
        rst       = 1'b0;

        vecs[0]  = '{0,       3'd0,  65536,      0};
        vecs[1]  = '{51472,   3'd0,  46341,  46341};
        vecs[2]  = '{-51472,  3'd0,  46341, -46341};
        vecs[3]  = '{0,       3'd1,      0,  65536};
        vecs[4]  = '{0,       3'd2, -65536,      0};
        vecs[5]  = '{0,       3'd3, -65536,      0};
        vecs[6]  = '{0,       3'd4,      0, -65536};
        vecs[7]  = '{25736,   3'd0,  60548,  25079};
        vecs[8]  = '{25736,   3'd2, -60548, -25079};
        vecs[9]  = '{51472,   3'd1, -46341,  46341};
        vecs[10] = '{51472,   3'd4,  46341, -46341};
        vecs[11] = '{-25736,  3'd6,  60548, -25079};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst cos", int'(cos_out), 0, 0);
        chk("rst sin", int'(sin_out), 0, 0);
        chk("rst done", int'(done), 0, 0);
        chk("rst busy", int'(busy), 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst done", int'(done), 0, 0);
        chk("post_rst busy", int'(busy), 0, 0);

        // Table-driven vectors
        for (int k = 0; k < 12; k++) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            start_op(vecs[k].z, vecs[k].q, nm, lat);
            if (lat > 0) begin
                chk({nm, " cos"}, int'(cos_out), vecs[k].exp_cos, TOL);
                chk({nm, " sin"}, int'(sin_out), vecs[k].exp_sin, TOL);
                @(posedge clk);
                #1;
                chk({nm, " done_one_cycle"}, int'(done), 0, 0);
                chk({nm, " busy_idle"}, int'(busy), 0, 0);
                chk({nm, " cos_hold"}, int'(cos_out), vecs[k].exp_cos, TOL);
            end
        end

        // Enable re-asserted with another angle during ROTATE must be ignored
        @(negedge clk);
        enable    = 1'b1;
        z_in      = 32'sd0;
        quadrante = 3'd0;
        @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable    = 1'b1;
        z_in      = 32'sd51472;
        quadrante = 3'd4;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        dones  = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                chk("ignore cos", int'(cos_out), 65536, TOL);
                chk("ignore sin", int'(sin_out), 0, TOL);
            end
        end
        chk("ignore done_count", dones, 1, 0);

        // Reset asserted at iteration 8 aborts without a done
        @(negedge clk);
        enable    = 1'b1;
        z_in      = 32'sd51472;
        quadrante = 3'd0;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort cos", int'(cos_out), 0, 0);
        chk("abort sin", int'(sin_out), 0, 0);
        chk("abort busy", int'(busy), 0, 0);
        @(negedge clk);
        rst   = 1'b1;
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("abort no_done", dones, 0, 0);
        chk("abort cos_hold", int'(cos_out), 0, 0);
        chk("abort sin_hold", int'(sin_out), 0, 0);
        start_op(25736, 3'd0, "after_abort", lat);
        chk("after_abort cos", int'(cos_out), 60548, TOL);
        chk("after_abort sin", int'(sin_out), 25079, TOL);

        // Enable held high: one result every ITER+2 cycles
        @(negedge clk);
        enable    = 1'b1;
        z_in      = 32'sd0;
        quadrante = 3'd1;
        @(posedge clk);
        #1;
        wait_done(lat);
        chk("b2b first latency", lat, 17, 0);
        wait_done(lat);
        enable = 1'b0;
        chk("b2b period", lat, 18, 0);
        chk("b2b cos", int'(cos_out), 0, TOL);
        chk("b2b sin", int'(sin_out), 65536, TOL);
        repeat (25) @(posedge clk);
        #1;
        chk("b2b idle busy", int'(busy), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_rotacao_seno_cosseno.md
Name: cordic_rotacao_seno_cosseno

Overview:
- Iterative CORDIC rotation-mode engine. It sits directly downstream of the quadrant-correction stage.
- Consumes the corrected angle z (Q16.16, range [-π/4, π/4]) and the 3-bit quadrant code, runs ITER shift-add micro-rotations, then maps the result back to the original quadrant.
- Emits cos/sin of the original angle in Q16.16 with a one-cycle done pulse.
- enable is driven by the upstream done.

Parameters:
- WIDTH, 32, data width of z_in/cos_out/sin_out and internal x/y/z registers; Q16.16 format.
- ITER, 16, number of micro-rotations; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- enable  input  1  start request; sampled only in IDLE.
- z_in  input  WIDTH  signed corrected angle, Q16.16, expected within [-51472, 51472].
- quadrante  input  3  quadrant code from the upstream stage (0..4).
- cos_out  output  WIDTH  signed cos(θ), Q16.16.
- sin_out  output  WIDTH  signed sin(θ), Q16.16.
- busy  output  1  high in ROTATE and CORRECT.
- done  output  1  one-cycle pulse when cos_out/sin_out are updated.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; x, y, z, iteration counter and latched quadrant cleared.
  - cos_out=0, sin_out=0, done=0, busy=0.
  - Reset mid-operation aborts the computation. No done is generated; outputs return to 0.
- Constants:
  - x0 = 1/K = 39797 (0.607253).
  - y0 = 0.
  - atan table atan(2^-i)·65536 for i=0..15: 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2.
- IDLE:
  - done=0.
  - If enable=1: latch x=39797, y=0, z=z_in, q=quadrante, i=0; go to ROTATE.
  - Otherwise stay in IDLE.
- ROTATE: one micro-rotation per clock.
  - d=+1 if z≥0, else -1.
  - x ← x − d·(y>>>i), y ← y + d·(x>>>i), z ← z − d·atan[i], using old x/y on both right-hand sides.
  - >>> is an arithmetic shift; all arithmetic is signed WIDTH-bit with two's-complement wrap and no saturation.
  - i increments each cycle. After the iteration with i=ITER−1, go to CORRECT.
- CORRECT (one cycle): register outputs from the final (x,y)=(c,s) according to q:
  - q=0 → cos=c, sin=s.
  - q=1 (θ=z+π/2) → cos=−s, sin=c.
  - q=2 or q=3 (θ=z+π) → cos=−c, sin=−s.
  - q=4 (θ=z−π/2) → cos=s, sin=−c.
  - q=5..7 → treated as 0.
  - Set done=1 and go to IDLE.
- Latency:
  - enable sampled at edge E0; iterations at E1..E_ITER; outputs and done registered at E_(ITER+1).
  - done is high for exactly one cycle and cleared at E_(ITER+2).
- Simultaneous events and boundaries:
  - enable while busy=1 is ignored, not queued.
  - enable held high restarts at the first IDLE edge after done, so back-to-back throughput is one result per ITER+2 cycles.
  - cos_out/sin_out hold their last value between completions.
  - z_in outside ±π/4 is not checked; the result is only accurate within CORDIC convergence (|z| ≤ ~1.74 rad).

Test Plan:
- Reset, then release rst → cos_out=0, sin_out=0, done=0, busy=0; state IDLE.
- z_in=0, quadrante=0, enable pulse → done exactly 17 cycles after the sampling edge (ITER=16); cos_out=65536±16, sin_out=0±16.
- z_in=51472, quadrante=0 → cos_out and sin_out both 46341±16.
- z_in=0 with quadrante=1 / 2 / 3 / 4 → (cos,sin) = (0, 65536) / (−65536, 0) / (−65536, 0) / (0, −65536), each ±16.
- enable re-asserted with a different z_in during ROTATE → ignored; result matches the first request, and only one done pulse is produced.
- rst=0 asserted at iteration 8, then released with enable=0 → no done; outputs 0; the next enable produces a correct result after 17 cycles.
